// File: rtl/prog_readback_pkg.sv
// Shared constants and FSM state type for the program-memory serial readback engine.
package prog_readback_pkg;

  localparam int unsigned ADDR_W       = 10;
  localparam int unsigned DATA_W       = 18;
  localparam int unsigned FRAME_W      = 28;
  localparam logic [9:0]  TRAILER_MARK = 10'h3FF;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StShift,
    StTrailer,
    StDone
  } state_e;

endpackage

// File: rtl/prog_readback_ser.sv
// Frame serializer: parallel load, MSB-first shift-out and bit counter behind a
// valid/ready handshake. last_accepted flags the handshake on the final bit.
module prog_readback_ser import prog_readback_pkg::*; #(
  parameter int unsigned FrameW = FRAME_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [FrameW-1:0] frame_in,
  input  logic              sout_ready,
  output logic              sout,
  output logic              sout_valid,
  output logic              last_accepted
);

  localparam int unsigned     CntW    = $clog2(FrameW);
  localparam logic [CntW-1:0] CntLast = CntW'(FrameW - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [FrameW-1:0] shift_q;
  logic [CntW-1:0]   cnt_q;
  logic              valid_q;
  logic              accept;

  assign accept        = valid_q & sout_ready;
  assign last_accepted = accept & (cnt_q == '0);
  assign sout          = shift_q[FrameW-1];
  assign sout_valid    = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      shift_q <= frame_in;
      cnt_q   <= CntLast;
      valid_q <= 1'b1;
    end else if (accept) begin
      shift_q <= {shift_q[FrameW-2:0], 1'b0};
      if (cnt_q == '0) begin
        valid_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CntOne;
      end
    end
  end

endmodule

// File: rtl/prog_readback.sv
// Program-RAM readback engine: fetches a word range and streams address/data frames serially.
// Define PROG_READBACK_CSUM_EN to keep a running checksum and append a 3FF/checksum trailer frame.
module prog_readback #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              sout,
  output logic              sout_valid,
  input  logic              sout_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  import prog_readback_pkg::*;

  localparam int unsigned       FrameW  = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
  localparam logic [ADDR_W:0]   RemOne  = (ADDR_W + 1)'(1);

  state_e            state_q;
  logic [ADDR_W:0]   remain_q;
  logic              start_go;
  logic              load;
  logic              last_accepted;
  logic [FrameW-1:0] frame_in;

  assign start_go = (state_q == StIdle) & start & ~abort;
  // The frame is captured on the edge that leaves WAIT, so the inter-frame gap is two cycles.
  assign load     = (state_q == StWait) & ~abort;

`ifdef PROG_READBACK_CSUM_EN
  logic              trailer_q;
  logic [DATA_W-1:0] csum_q;

  assign frame_in = trailer_q ? {ADDR_W'(TRAILER_MARK), csum_q} : {mem_addr, mem_data};
  assign checksum = csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (start_go) begin
      csum_q <= '0;
    end else if (load && !trailer_q) begin
      csum_q <= csum_q + mem_data;
    end
  end
`else
  assign frame_in = {mem_addr, mem_data};
  assign checksum = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      remain_q  <= '0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef PROG_READBACK_CSUM_EN
      trailer_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (abort && state_q != StIdle) begin
        state_q <= StIdle;
        busy    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_go) begin
              mem_addr  <= start_addr;
              remain_q  <= word_count;
              busy      <= 1'b1;
`ifdef PROG_READBACK_CSUM_EN
              trailer_q <= 1'b0;
`endif
              if (word_count == '0) begin
                state_q <= StDone;
                done    <= 1'b1;
              end else begin
                state_q <= StFetch;
              end
            end
          end
          StFetch: state_q <= StWait;
          StWait: begin
`ifdef PROG_READBACK_CSUM_EN
            if (trailer_q) begin
              state_q <= StTrailer;
            end else begin
              remain_q <= remain_q - RemOne;
              state_q  <= StShift;
            end
`else
            remain_q <= remain_q - RemOne;
            state_q  <= StShift;
`endif
          end
          StShift: begin
            if (last_accepted) begin
              if (remain_q != '0) begin
                mem_addr <= mem_addr + AddrOne;
                state_q  <= StFetch;
              end else begin
`ifdef PROG_READBACK_CSUM_EN
                // Reuse the FETCH/WAIT gap ahead of the trailer frame.
                trailer_q <= 1'b1;
                state_q   <= StFetch;
`else
                state_q <= StDone;
                done    <= 1'b1;
`endif
              end
            end
          end
`ifdef PROG_READBACK_CSUM_EN
          StTrailer: begin
            if (last_accepted) begin
              state_q <= StDone;
              done    <= 1'b1;
            end
          end
`endif
          StDone: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  prog_readback_ser #(
    .FrameW(FrameW)
  ) u_ser (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (abort),
    .load         (load),
    .frame_in     (frame_in),
    .sout_ready   (sout_ready),
    .sout         (sout),
    .sout_valid   (sout_valid),
    .last_accepted(last_accepted)
  );

endmodule

// File: tb/tb_prog_readback.sv
// Scoreboard bench for prog_readback: a word-level model queues expected bits, a monitor pops them.
module tb_prog_readback;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 18;
  localparam int unsigned FW = 28;
`ifdef PROG_READBACK_CSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          sout_ready = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   word_count = '0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          sout, sout_valid, busy, done;
  logic [DW-1:0] checksum;

  logic [DW-1:0] ram [1024];
  int unsigned   cyc = 0;
  int unsigned   checks = 0;
  int unsigned   errors = 0;
  bit            exp_q[$];
  logic [DW-1:0] exp_sum;
  int unsigned   acc_cnt = 0, done_cnt = 0, busy_cnt = 0, rise_cnt = 0;
  int unsigned   done_cyc = 0, rise_cyc = 0, last_acc_cyc = 0;
  bit            rand_ready = 1'b0;

  prog_readback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .word_count(word_count),
    .abort     (abort),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .sout      (sout),
    .sout_valid(sout_valid),
    .sout_ready(sout_ready),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_data <= ram[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Expected stream: one frame per word at consecutive (wrapping) addresses, then the trailer.
  task automatic push_model(input logic [AW-1:0] sa, input int unsigned n);
    logic [FW-1:0] f;
    int unsigned   a;
    exp_sum = '0;
    for (int i = 0; i < int'(n); i++) begin
      a = (int'(sa) + i) % 1024;
      f = {AW'(a), ram[a]};
      exp_sum = exp_sum + ram[a];
      for (int b = FW - 1; b >= 0; b--) exp_q.push_back(f[b]);
    end
    if (CsumEn) begin
      f = {10'h3FF, exp_sum};
      for (int b = FW - 1; b >= 0; b--) exp_q.push_back(f[b]);
    end
  endtask

  task automatic run_start(input logic [AW-1:0] sa, input int unsigned n, output int unsigned c0);
    @(posedge clk);
    #1;
    start_addr = sa;
    word_count = (AW + 1)'(n);
    start      = 1'b1;
    push_model(sa, n);
    @(posedge clk);
    #1;
    c0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned base, input int unsigned limit);
    int unsigned n;
    n = 0;
    while (done_cnt == base && n < limit) begin
      step();
      n++;
    end
    checks++;
    if (done_cnt == base) begin
      errors++;
      $display("FAIL wait_done: no done pulse within %0d cycles, required one", limit);
    end
  endtask

  initial begin
    int unsigned   c0, b_done, b_busy, b_rise, b_acc, n;
    logic [AW-1:0] sa, sa1;
    logic [DW-1:0] part;

    for (int i = 0; i < 1024; i++) ram[i] = DW'($urandom);

    fork
      begin : monitor
        bit          prev_stall, prev_sout, prev_valid, e;
        int unsigned low_run;
        prev_stall = 1'b0; prev_sout = 1'b0; prev_valid = 1'b0; low_run = 0;
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            prev_stall = 1'b0; prev_sout = 1'b0; prev_valid = 1'b0; low_run = 0;
          end else begin
            if (prev_stall) begin
              chk("stall_sout_hold", sout, prev_sout);
              chk("stall_valid_hold", sout_valid, 1);
            end
            if (sout_valid && !prev_valid) begin
              rise_cnt++;
              rise_cyc = cyc;
              if (busy) chk("gap_cycles", low_run, 2);
            end
            if (sout_valid && sout_ready) begin
              acc_cnt++;
              last_acc_cyc = cyc;
              if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sout_bit: got unexpected bit %0b, expected none", sout);
              end else begin
                e = exp_q.pop_front();
                chk("sout_bit", sout, e);
              end
            end
            if (done) begin
              done_cnt++;
              done_cyc = cyc;
            end
            if (busy) busy_cnt++;
            prev_stall = sout_valid && !sout_ready;
            prev_sout  = sout;
            prev_valid = sout_valid;
            low_run    = (busy && !sout_valid) ? low_run + 1 : 0;
          end
        end
      end
      begin : ready_drv
        forever begin
          @(posedge clk);
          #1;
          sout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    step();
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_sout", sout, 0);
    chk("rst_sout_valid", sout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_checksum", checksum, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) step();

    // Single word at address 0
    ram[0] = 18'h2C2FF;
    b_done = done_cnt;
    run_start(10'h000, 1, c0);
    wait_done(b_done, 200);
    chk("first_valid_latency", rise_cyc - c0, 2);
    chk("done_after_last_accept", done_cyc - last_acc_cyc, 1);
    chk("single_checksum", checksum, CsumEn ? 32'h2C2FF : 32'h0);
    chk("single_queue_empty", exp_q.size(), 0);

    // Address wrap across 0x3FF
    b_done = done_cnt;
    b_rise = rise_cnt;
    run_start(10'h3FE, 3, c0);
    wait_done(b_done, 400);
    chk("wrap_frames", rise_cnt - b_rise, 3 + int'(CsumEn));
    chk("wrap_first_latency", (rise_cyc >= c0) ? 1 : 0, 1);
    chk("wrap_checksum", checksum, CsumEn ? exp_sum : '0);
    chk("wrap_queue_empty", exp_q.size(), 0);

    // 16 words with random ready stalls
    rand_ready = 1'b1;
    b_done = done_cnt;
    sa = AW'($urandom);
    run_start(sa, 16, c0);
    wait_done(b_done, 3000);
    rand_ready = 1'b0;
    chk("stall_checksum", checksum, CsumEn ? exp_sum : '0);
    chk("stall_queue_empty", exp_q.size(), 0);
    chk("stall_done_latency", done_cyc - last_acc_cyc, 1);

    // Zero-length readback
    repeat (2) step();
    b_done = done_cnt;
    b_busy = busy_cnt;
    b_rise = rise_cnt;
    run_start(AW'($urandom), 0, c0);
    repeat (4) step();
    chk("zero_done_count", done_cnt - b_done, 1);
    chk("zero_done_cycle", done_cyc, c0);
    chk("zero_busy_cycles", busy_cnt - b_busy, 1);
    chk("zero_no_valid", rise_cnt - b_rise, 0);
    chk("zero_checksum", checksum, 0);

    // Abort in the middle of frame 2 of 4
    b_done = done_cnt;
    b_acc  = acc_cnt;
    sa  = AW'($urandom);
    sa1 = sa + 10'd1;
    part = ram[sa] + ram[sa1];
    run_start(sa, 4, c0);
    n = 0;
    while (acc_cnt - b_acc < FW + 10 && n < 500) begin
      step();
      n++;
    end
    chk("abort_reached_frame2", (acc_cnt - b_acc >= FW + 10) ? 1 : 0, 1);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_valid_low", sout_valid, 0);
    chk("abort_busy_low", busy, 0);
    exp_q.delete();
    repeat (40) step();
    chk("abort_no_done", done_cnt - b_done, 0);
    chk("abort_partial_checksum", checksum, CsumEn ? part : '0);

    // abort and start together in IDLE: nothing starts
    b_rise = rise_cnt;
    b_done = done_cnt;
    @(posedge clk);
    #1;
    start_addr = AW'($urandom);
    word_count = 11'd2;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (5) step();
    chk("abort_start_busy", busy, 0);
    chk("abort_start_no_valid", rise_cnt - b_rise, 0);
    chk("abort_start_no_done", done_cnt - b_done, 0);

    // Clean readback after abort
    b_done = done_cnt;
    run_start(AW'($urandom), 2, c0);
    wait_done(b_done, 400);
    chk("post_abort_queue_empty", exp_q.size(), 0);
    chk("post_abort_checksum", checksum, CsumEn ? exp_sum : '0);

    // Known checksum words, including a wrap of the 18-bit sum
    ram[10'h100] = 18'h3FFFF;
    ram[10'h101] = 18'h00001;
    ram[10'h102] = 18'h00010;
    ram[10'h103] = 18'h00100;
    b_done = done_cnt;
    run_start(10'h100, 4, c0);
    wait_done(b_done, 400);
    chk("known_checksum", checksum, CsumEn ? 32'h00110 : 32'h0);
    chk("known_queue_empty", exp_q.size(), 0);
    chk("known_done_latency", done_cyc - last_acc_cyc, 1);

    // Reset mid-operation
    b_done = done_cnt;
    run_start(AW'($urandom), 5, c0);
    repeat (20) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_sout", sout, 0);
    chk("midrst_sout_valid", sout_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_checksum", checksum, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) step();
    chk("midrst_no_done", done_cnt - b_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_readback.md
# prog_readback

Serial readback engine for the 1024 x 18 PicoBlaze program memory. The serial loader writes instruction words into the program block RAM through its spare port. This block is the reader on that port. It fetches a range of words and streams each one out as an address/data frame over a bit-serial valid/ready link, so a host can verify the image after an upload. It sits beside the program RAM and drives that RAM's spare read port.

## Interface
Parameters:
- ADDR_W, 10, program memory address width
- DATA_W, 18, instruction word width

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a readback; ignored while busy
- start_addr  in  ADDR_W  first word address, sampled with start
- word_count  in  ADDR_W+1  number of words, 0..1024, sampled with start
- abort  in  1  cancels a readback in progress
- mem_addr  out  ADDR_W  registered read address to the program RAM spare port
- mem_data  in  DATA_W  RAM read data, valid one cycle after mem_addr
- sout  out  1  current serial bit
- sout_valid  out  1  sout holds a valid bit
- sout_ready  in  1  host accepts the bit when sout_valid & sout_ready
- busy  out  1  readback in progress
- done  out  1  one-cycle pulse when a readback completes normally
- checksum  out  DATA_W  running modulo-2^18 sum of the data words read

## Operation
- Frame: 28 bits, MSB first: address[9:0] then data[17:0].
- States:
  - IDLE: start → FETCH, but if word_count=0 → DONE.
  - FETCH: mem_addr presented → WAIT.
  - WAIT: RAM latency → LOAD.
  - LOAD: capture {addr, mem_data} into the 28-bit shift register, add data to checksum, bit counter=27 → SHIFT.
  - SHIFT: on each accept, shift left and decrement. On the accept at counter=0: if words remain, mem_addr+1 → FETCH; otherwise → DONE (or TRAILER when the macro is defined).
  - DONE: done=1 for one cycle → IDLE.
- Address increments modulo 1024, so 0x3FF wraps to 0x000.
- The checksum clears on start and holds its value after DONE until the next start.
- abort in any non-IDLE state → IDLE on the next edge:
  - sout_valid and busy drop.
  - done is not pulsed.
  - checksum holds its partial value.
- abort and start in the same cycle in IDLE: abort wins, nothing starts.
- sout_valid stays asserted while sout_ready is low. sout and the shift register hold until the bit is accepted.
- busy=1 in every state except IDLE.

## Timing
- Reset values: mem_addr=0, sout=0, sout_valid=0, busy=0, done=0, checksum=0, state IDLE.
- Start sampled at edge E0:
  - mem_addr valid after E0.
  - mem_data valid after E1.
  - Shift register loaded at E2.
  - sout_valid=1 after E2.
- Accepted bits: one per cycle at most.
- Full throughput (sout_ready held high): a frame takes 28 cycles.
- Inter-frame gap: exactly 2 cycles with sout_valid=0 (FETCH, WAIT).
- done: pulses the cycle after the last bit is accepted (after the trailer when enabled).
- busy: falls together with the done pulse.
- Reset asserted mid-operation: all outputs return to reset values immediately; no done pulse.

## Configuration
- PROG_READBACK_CSUM_EN defined:
  - After the last word, a TRAILER state sends one extra 28-bit frame: 10'h3FF marker followed by checksum[17:0].
  - The trailer uses the same handshake and is preceded by the same 2-cycle gap.
  - done pulses after the trailer's last bit.
- Not defined:
  - No TRAILER state.
  - checksum is tied to 0 and the adder is omitted.
  - done pulses directly after the last data frame.

## Structure
- Shared package prog_readback_pkg holds:
  - ADDR_W, DATA_W, FRAME_W=28, TRAILER_MARK=10'h3FF
  - the state enum type
- One natural sub-module, prog_readback_ser: the 28-bit load/shift register, bit counter and valid/ready handshake. It exposes load, frame_in and last_accepted to the parent FSM.

## Test plan
- start_addr=0x000, word_count=1, RAM[0]=0x2C2FF, sout_ready=1 → 28 bits 0000000000_101100001011111111; sout_valid first high 2 cycles after start; done 1 cycle after the last accept; checksum=0x2C2FF.
- start_addr=0x3FE, word_count=3 → frames carry addresses 0x3FE, 0x3FF, 0x000; exactly 2 sout_valid-low cycles between frames.
- Random sout_ready stalls (~50% duty) over 16 words → bit stream identical to the no-stall run; sout stable while stalled.
- word_count=0 → no sout_valid; done pulses 1 cycle after start; busy high for exactly 1 cycle.
- abort asserted mid-frame 2 of 4 → sout_valid and busy low the next cycle; no done; a new start then runs a clean readback.
- With PROG_READBACK_CSUM_EN: 4 words 0x3FFFF, 0x00001, 0x00010, 0x00100 → trailer frame 3FF_00110 (mod 2^18); done only after the trailer.
